// File: rtl/simple_spi_slave_rw_pkg.sv
// Shared types for the mode-0 SPI responder.
package simple_spi_slave_rw_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/simple_spi_slave_rw_sync_edge.sv
// Multi-flop synchronizer with level and rise/fall pulse outputs.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              q_d;

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      sr  <= '0;
      q_d <= 1'b0;
    end else begin
      sr  <= {sr[STAGES-2:0], d};
      q_d <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/simple_spi_slave_rw.sv
// SPI mode-0 responder, oversampled in the CLK domain, word-oriented.
module simple_spi_slave_rw
  import simple_spi_slave_rw_pkg::*;
#(
  parameter int REG_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         rstn,
  input  logic [REG_WIDTH-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [REG_WIDTH-1:0]         rx_data,
  output logic [$clog2(REG_WIDTH):0]   rx_bits,
  output logic                         rx_valid,
  output logic                         tx_underrun,
  input  logic                         spi_clk,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(REG_WIDTH);
  localparam logic [CW:0]  W_CNT = (CW+1)'(REG_WIDTH);
  localparam logic [W-1:0] ONES  = '1;

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  state_t state_q, state_d;

  logic [W-1:0] tx_buf, tx_sh, rx_sh;
  logic         buf_full, word_done;
  logic [CW:0]  bit_cnt;

  logic [W-1:0] rx_sh_sh, rx_sh_now, rx_mask;
  logic [CW:0]  cnt_inc, cnt_now;
  logic act, clk_rise_act, clk_fall_act, word_end;
  logic frame_start, reload, part, wr;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .CLK  (CLK),
    .rstn (rstn),
    .d    (spi_clk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .CLK  (CLK),
    .rstn (rstn),
    .d    (spi_cs_n),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge CLK) begin
    if (!rstn) mosi_sr <= '0;
    else       mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  // Leave RESYNC only once the bus is idle, never mid-frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESYNC: if (cs_q && !sclk_q) state_d = IDLE;
      IDLE:   if (cs_fall)         state_d = ACTIVE;
      ACTIVE: if (cs_rise)         state_d = IDLE;
      default:                     state_d = RESYNC;
    endcase
  end

  always_comb begin
    act          = (state_q == ACTIVE);
    clk_rise_act = act & sclk_rise;
    clk_fall_act = act & sclk_fall;
    rx_sh_sh     = {rx_sh[W-2:0], mosi_q};
    cnt_inc      = bit_cnt + 1'b1;
    word_end     = clk_rise_act & (cnt_inc == W_CNT);
    rx_sh_now    = clk_rise_act ? rx_sh_sh : rx_sh;
    cnt_now      = bit_cnt;
    if (clk_rise_act) cnt_now = word_end ? '0 : cnt_inc;
    rx_mask      = ~(ONES << cnt_now);
    frame_start  = (state_q == IDLE) & cs_fall;
    reload       = frame_start | (clk_fall_act & word_done);
    // A clock rise in the closing cycle is folded in before the close.
    part         = act & cs_rise & (cnt_now != '0);
    wr           = tx_valid & tx_ready;
  end

  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state_q     <= RESYNC;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      rx_data     <= '0;
      rx_bits     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (wr) tx_buf <= tx_data;
      buf_full <= wr | (buf_full & ~reload);

      if (reload) begin
        tx_sh       <= buf_full ? tx_buf : '0;
        tx_underrun <= ~buf_full;
      end else if (clk_fall_act) begin
        tx_sh <= {tx_sh[W-2:0], 1'b0};
      end

      if (frame_start)       word_done <= 1'b0;
      else if (word_end)     word_done <= 1'b1;
      else if (clk_fall_act) word_done <= 1'b0;

      if (frame_start) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (clk_rise_act) begin
        bit_cnt <= cnt_now;
        rx_sh   <= rx_sh_sh;
      end

      if (word_end) begin
        rx_data  <= rx_sh_sh;
        rx_bits  <= W_CNT;
        rx_valid <= 1'b1;
      end else if (part) begin
        rx_data  <= rx_sh_now & rx_mask;
        rx_bits  <= cnt_now;
        rx_valid <= 1'b1;
      end
    end
  end

  assign tx_ready    = ~buf_full;
  assign spi_miso_oe = (state_q == ACTIVE);
  assign spi_miso    = spi_miso_oe & tx_sh[W-1];

endmodule

// File: tb/tb_simple_spi_slave_rw.sv
// Bench: SPI master model at CLK/8 against a word-slot reference model.
module tb_simple_spi_slave_rw;

  logic       CLK = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [3:0] rx_bits;
  logic       rx_valid;
  logic       tx_underrun;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;

  always #5 CLK = ~CLK;

  simple_spi_slave_rw #(.REG_WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK         (CLK),
    .rstn        (rstn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_bits     (rx_bits),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] feed_q[$];
  logic [7:0] mdl_q[$];
  int         urun_cnt = 0;
  logic [7:0] got_d[$];
  logic [3:0] got_b[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Producer: offers the head of feed_q until it is taken.
  always @(posedge CLK) begin
    if (rstn && tx_valid && tx_ready) void'(feed_q.pop_front());
    #1;
    tx_valid = (feed_q.size() > 0);
    tx_data  = tx_valid ? feed_q[0] : 8'h00;
  end

  always @(negedge CLK) begin
    if (tx_underrun) urun_cnt++;
    if (rx_valid) begin
      got_d.push_back(rx_data);
      got_b.push_back(rx_bits);
    end
  end

  task automatic push(input logic [7:0] w);
    feed_q.push_back(w);
    mdl_q.push_back(w);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    wait_n(4);
    spi_clk = 1'b1;
    r = spi_miso;
    wait_n(4);
    spi_clk = 1'b0;
  endtask

  // One CS frame of nb bits; dat[nb-1] goes first.
  task automatic frame(input int nb, input logic [63:0] dat,
                       input string tag);
    logic [63:0] rin, exp_miso, ed;
    logic [7:0]  slot[$];
    logic [7:0]  w;
    logic        r;
    int loads, ue, u0, nfull, m, nexp;
    rin = '0;
    exp_miso = '0;
    ue = 0;
    nfull = nb / 8;
    m = nb % 8;
    // Every completed word opens a new slot, even right before CS rises.
    loads = 1 + nfull;
    for (int j = 0; j < loads; j++) begin
      if (mdl_q.size() > 0) slot.push_back(mdl_q.pop_front());
      else begin
        slot.push_back(8'h00);
        ue++;
      end
    end
    for (int i = 0; i < nb; i++) begin
      w = slot[i/8];
      exp_miso = {exp_miso[62:0], w[7 - (i % 8)]};
    end
    wait_n(4);
    u0 = urun_cnt;
    got_d.delete();
    got_b.delete();
    spi_cs_n = 1'b0;
    wait_n(8);
    for (int i = 0; i < nb; i++) begin
      spi_bit(dat[nb-1-i], r);
      rin = {rin[62:0], r};
    end
    wait_n(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_n(12);
    nexp = nfull + ((m != 0) ? 1 : 0);
    check({tag, ".miso"}, rin, exp_miso);
    check({tag, ".urun"}, 64'(urun_cnt - u0), 64'(ue));
    check({tag, ".nrx"}, 64'(got_d.size()), 64'(nexp));
    for (int k = 0; k < nexp; k++) begin
      if (k < nfull) ed = (dat >> (nb - 8*(k+1))) & 64'hFF;
      else           ed = dat & ((64'd1 << m) - 64'd1);
      check({tag, ".rxd"}, (k < got_d.size()) ? 64'(got_d[k]) : 'x, ed);
      check({tag, ".rxb"}, (k < got_b.size()) ? 64'(got_b[k]) : 'x,
            (k < nfull) ? 64'd8 : 64'(m));
    end
  endtask

  initial begin
    logic r;
    logic [63:0] d;
    int nb, np;

    wait_n(4);
    check("rst.tx_ready", 64'(tx_ready), 64'd1);
    check("rst.rx_data", 64'(rx_data), 64'd0);
    check("rst.rx_bits", 64'(rx_bits), 64'd0);
    check("rst.rx_valid", 64'(rx_valid), 64'd0);
    check("rst.urun", 64'(tx_underrun), 64'd0);
    check("rst.miso", 64'(spi_miso), 64'd0);
    check("rst.oe", 64'(spi_miso_oe), 64'd0);
    rstn = 1'b1;
    wait_n(8);

    push(8'hA5);
    wait_n(4);
    check("t1.tx_ready", 64'(tx_ready), 64'd0);
    frame(8, 64'h3C, "t1");

    frame(8, 64'h96, "t2");

    push(8'h11);
    push(8'h22);
    frame(16, 64'hC3E7, "t3");
    check("t3.tx_ready", 64'(tx_ready), 64'd1);

    frame(5, 64'b10110, "t4");

    got_d.delete();
    spi_cs_n = 1'b0;
    wait_n(8);
    spi_bit(1'b1, r);
    spi_bit(1'b0, r);
    spi_bit(1'b1, r);
    rstn = 1'b0;
    wait_n(3);
    check("t5.rst_oe", 64'(spi_miso_oe), 64'd0);
    check("t5.rst_ready", 64'(tx_ready), 64'd1);
    rstn = 1'b1;
    feed_q.delete();
    mdl_q.delete();
    wait_n(6);
    spi_bit(1'b1, r);
    wait_n(6);
    check("t5.oe_resync", 64'(spi_miso_oe), 64'd0);
    check("t5.no_rx", 64'(got_d.size()), 64'd0);
    spi_cs_n = 1'b1;
    wait_n(8);
    frame(8, 64'h5B, "t5");

    frame(0, 64'h0, "t6a");
    push(8'h5A);
    frame(0, 64'h0, "t6b");
    check("t6.tx_ready", 64'(tx_ready), 64'd1);

    for (int it = 0; it < 6; it++) begin
      nb = $urandom_range(1, 24);
      np = $urandom_range(0, 3);
      d = {$urandom, $urandom};
      for (int p = 0; p < np; p++) push(8'($urandom));
      frame(nb, d, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
